// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the four-port core-memory arbiter.
// Latency: none (declarations only).
// Backpressure: n/a. Used with or without MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  localparam int NPORT   = 4;
  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 36;
  localparam int GRANT_W = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    RD    = 3'd2,
    RS    = 3'd3,
    WWAIT = 3'd4,
    WR    = 3'd5
  } arb_state_t;

  // Bit 0 = read part, bit 1 = write part.
  typedef enum logic [1:0] {
    CYC_NONE = 2'b00,
    CYC_RD   = 2'b01,
    CYC_WR   = 2'b10,
    CYC_RW   = 2'b11
  } cyc_t;

  // Per-cycle header captured at grant time.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    cyc_t              typ;
  } cyc_hdr_t;

  function automatic cyc_t cyc_encode(input logic rd, input logic wr);
    return cyc_t'({wr, rd});
  endfunction

  function automatic logic cyc_has_rd(input cyc_t c);
    return (c == CYC_RD) || (c == CYC_RW);
  endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational NPORT-way picker: first eligible port at or after start.
// Latency: zero cycles (pure combinational).
// Backpressure: none; caller decides when the result is consumed.
module arb_prio_pick
  import mem_arb_pkg::*;
(
  input  logic [NPORT-1:0]   elig,
  input  logic [GRANT_W-1:0] start,
  output logic               vld,
  output logic [GRANT_W-1:0] idx
);

  logic [GRANT_W-1:0] pos;

  // Scan offsets from farthest to nearest so the nearest eligible port wins;
  // the GRANT_W-bit add wraps modulo NPORT because NPORT is a power of two.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    pos = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      pos = start + GRANT_W'(i);
      if (elig[pos]) begin
        vld = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Four-port arbiter/sequencer for one core array; runs read, write or read-pause-write cycles.
// Latency: addr_ack 1 cycle after grant, core_rd 2, rd_rs 3+L, restore core_wr 4+L (L = core latency).
// Backpressure: one cycle at a time; other ports wait in IDLE. MEM_ARB_ROUND_ROBIN_EN selects rotating priority.
module mem_port_arb
  import mem_arb_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NPORT-1:0]              sel_en,
  input  logic [NPORT-1:0]              rq_cyc,
  input  logic [NPORT-1:0]              rd_rq,
  input  logic [NPORT-1:0]              wr_rq,
  input  logic [NPORT-1:0][ADDR_W-1:0]  ma,
  input  logic [NPORT-1:0]              wr_rs,
  input  logic [NPORT-1:0][DATA_W-1:0]  mb_in,
  output logic [NPORT-1:0]              addr_ack,
  output logic [NPORT-1:0]              rd_rs,
  output logic [DATA_W-1:0]             mb_out,
  output logic                          busy,
  output logic [GRANT_W-1:0]            grant,
  output logic                          core_rd,
  output logic                          core_wr,
  output logic [ADDR_W-1:0]             core_addr,
  output logic [DATA_W-1:0]             core_wdata,
  input  logic [DATA_W-1:0]             core_rdata,
  input  logic                          core_done
);

  arb_state_t         state;
  arb_state_t         state_nxt;
  cyc_hdr_t           cyc_q;
  logic [DATA_W-1:0]  wb_q;
  logic               first_q;
  logic [NPORT-1:0]   elig;
  logic [GRANT_W-1:0] pick_start;
  logic               pick_vld;
  logic [GRANT_W-1:0] pick_idx;

  assign elig      = rq_cyc & sel_en & (rd_rq | wr_rq);
  assign busy      = (state != IDLE);
  assign core_addr = cyc_q.addr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [GRANT_W-1:0] last_grant;

  // Remember the previous winner; reset value makes port 0 win first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GRANT_W'(NPORT - 1);
    end else if ((state == IDLE) && pick_vld) begin
      last_grant <= pick_idx;
    end
  end

  assign pick_start = last_grant + GRANT_W'(1);
`else
  assign pick_start = '0;
`endif

  arb_prio_pick u_pick (
    .elig  (elig),
    .start (pick_start),
    .vld   (pick_vld),
    .idx   (pick_idx)
  );

  // State register plus a flag marking the first cycle spent in a state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      first_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      first_q <= (state_nxt != state);
    end
  end

  // Next-state and per-state output decode; strobes only in a state's first cycle.
  always_comb begin
    state_nxt = state;
    addr_ack  = '0;
    rd_rs     = '0;
    core_rd   = 1'b0;
    core_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) state_nxt = ACK;
      end
      ACK: begin
        addr_ack[grant] = 1'b1;
        state_nxt = cyc_has_rd(cyc_q.typ) ? RD : WWAIT;
      end
      RD: begin
        core_rd = first_q;
        if (core_done) state_nxt = RS;
      end
      RS: begin
        rd_rs[grant] = 1'b1;
        state_nxt = (cyc_q.typ == CYC_RD) ? WR : WWAIT;
      end
      WWAIT: begin
        if (wr_rs[grant] || !rq_cyc[grant]) state_nxt = WR;
      end
      WR: begin
        core_wr = first_q;
        if (core_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Cycle datapath: latch the winner in IDLE, capture read data, choose write data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant      <= '0;
      cyc_q      <= '0;
      wb_q       <= '0;
      mb_out     <= '0;
      core_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant      <= pick_idx;
            cyc_q.addr <= ma[pick_idx];
            cyc_q.typ  <= cyc_encode(rd_rq[pick_idx], wr_rq[pick_idx]);
            // Write-only cycles that are abandoned restore zero.
            wb_q       <= '0;
          end
        end
        RD: begin
          if (core_done) begin
            mb_out <= core_rdata;
            wb_q   <= core_rdata;
          end
        end
        RS: begin
          // Core reads are destructive: a read-only cycle writes the word back.
          if (cyc_q.typ == CYC_RD) core_wdata <= wb_q;
        end
        WWAIT: begin
          if (wr_rs[grant]) begin
            core_wdata <= mb_in[grant];
          end else if (!rq_cyc[grant]) begin
            core_wdata <= wb_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Scoreboard bench for mem_port_arb: directed cycles, expected events queued at issue time.
// Latency: events checked against hand-computed cycle numbers.
// Backpressure: a behavioural core model answers strobes after a programmable latency.
module tb_mem_port_arb;

  localparam int NP = 4;
  localparam int AW = 18;
  localparam int DW = 36;

  localparam int K_ACK = 0;
  localparam int K_CRD = 1;
  localparam int K_RS  = 2;
  localparam int K_CWR = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NP-1:0]        sel_en, rq_cyc, rd_rq, wr_rq, wr_rs;
  logic [NP-1:0][AW-1:0] ma;
  logic [NP-1:0][DW-1:0] mb_in;
  logic [NP-1:0]        addr_ack, rd_rs;
  logic [DW-1:0]        mb_out, core_wdata, core_rdata;
  logic                 busy;
  logic [1:0]           grant;
  logic                 core_rd, core_wr, core_done;
  logic [AW-1:0]        core_addr;

  typedef struct {
    int          kind;
    int          port;
    int          cyc;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } ev_t;

  ev_t           exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            core_lat = 0;
  logic [DW-1:0] rd_word = '0;
  bit            pending = 1'b0;
  int            done_at = 0;

  mem_port_arb dut (
    .clk        (clk),
    .reset      (reset),
    .sel_en     (sel_en),
    .rq_cyc     (rq_cyc),
    .rd_rq      (rd_rq),
    .wr_rq      (wr_rq),
    .ma         (ma),
    .wr_rs      (wr_rs),
    .mb_in      (mb_in),
    .addr_ack   (addr_ack),
    .rd_rs      (rd_rs),
    .mb_out     (mb_out),
    .busy       (busy),
    .grant      (grant),
    .core_rd    (core_rd),
    .core_wr    (core_wr),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_done  (core_done)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void push(input int k, input int p, input int c,
                               input logic [DW-1:0] d, input logic [AW-1:0] a);
    ev_t e;
    e.kind = k; e.port = p; e.cyc = c; e.data = d; e.addr = a;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input int k, input int p, input logic [DW-1:0] d, input logic [AW-1:0] a);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event kind=%0d port=%0d cyc=%0d", k, p, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.port != p || e.cyc != cyc || e.data !== d || e.addr !== a) begin
        bad++;
        $display("FAIL event got kind=%0d port=%0d cyc=%0d data=%o addr=%o want kind=%0d port=%0d cyc=%0d data=%o addr=%o",
                 k, p, cyc, d, a, e.kind, e.port, e.cyc, e.data, e.addr);
      end
    end
  endtask

  // Monitor: every observed output event is matched against the queue head.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      for (int p = 0; p < NP; p++) if (addr_ack[p]) check_ev(K_ACK, p, '0, '0);
      if (core_rd) check_ev(K_CRD, int'(grant), '0, core_addr);
      for (int p = 0; p < NP; p++) if (rd_rs[p]) check_ev(K_RS, p, mb_out, '0);
      if (core_wr) check_ev(K_CWR, int'(grant), core_wdata, core_addr);
    end
  end

  // Core model: core_done (with read data) core_lat cycles after a strobe.
  initial forever begin
    @(negedge clk);
    core_done = 1'b0;
    if (!reset) begin
      pending = 1'b0;
    end else begin
      if (core_rd || core_wr) begin
        pending = 1'b1;
        done_at = cyc + core_lat;
      end
      if (pending && cyc >= done_at) begin
        core_done  = 1'b1;
        core_rdata = rd_word;
        pending    = 1'b0;
      end
    end
  end

  task automatic at_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {63'd0, busy}, 64'd0);
  endtask

  task automatic run_read(input int p, input logic [AW-1:0] a, input logic [DW-1:0] w, input int l);
    int d;
    @(negedge clk);
    d = cyc;
    core_lat = l;
    rd_word = w;
    ma[p] = a; rd_rq[p] = 1'b1; wr_rq[p] = 1'b0; rq_cyc[p] = 1'b1;
    push(K_ACK, p, d + 1, '0, '0);
    push(K_CRD, p, d + 2, '0, a);
    push(K_RS,  p, d + 3 + l, w, '0);
    push(K_CWR, p, d + 4 + l, w, a);
    at_cyc(d + 4 + l);
    rq_cyc[p] = 1'b0; rd_rq[p] = 1'b0;
    wait_idle("read_done_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int seq[3];
    sel_en = '0; rq_cyc = '0; rd_rq = '0; wr_rq = '0; wr_rs = '0;
    ma = '0; mb_in = '0; core_rdata = '0; core_done = 1'b0;

    // Reset values.
    #3;
    chk("rst_strobes", {60'd0, core_rd, core_wr, busy, 1'b0}, 64'd0);
    chk("rst_acks", {56'd0, addr_ack, rd_rs}, 64'd0);
    chk("rst_grant", {62'd0, grant}, 64'd0);
    chk("rst_mb_out", {28'd0, mb_out}, 64'd0);
    chk("rst_core_addr", {46'd0, core_addr}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sel_en = 4'hF;
    @(negedge clk);

    // Ports 0 and 2 continuously requesting read-only cycles, L=0.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    seq[0] = 0; seq[1] = 2; seq[2] = 0;
`else
    seq[0] = 0; seq[1] = 0; seq[2] = 0;
`endif
    @(negedge clk);
    d = cyc;
    core_lat = 0;
    rd_word = 36'o707;
    ma[0] = 18'o1000; ma[2] = 18'o2000;
    rq_cyc[0] = 1'b1; rq_cyc[2] = 1'b1; rd_rq[0] = 1'b1; rd_rq[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(K_ACK, seq[k], d + 5*k + 1, '0, '0);
      push(K_CRD, seq[k], d + 5*k + 2, '0, ma[seq[k]]);
      push(K_RS,  seq[k], d + 5*k + 3, 36'o707, '0);
      push(K_CWR, seq[k], d + 5*k + 4, 36'o707, ma[seq[k]]);
    end
    at_cyc(d + 14);
    rq_cyc = '0; rd_rq = '0;
    wait_idle("prio_idle");

    // Port 1 read-only, L=3.
    run_read(1, 18'o10410, 36'o333, 3);

    // Port 0 write-only with stray wr_rs pulses that must be ignored.
    @(negedge clk);
    d = cyc;
    core_lat = 2;
    ma[0] = 18'o123456;
    mb_in[0] = 36'o111777222666;
    mb_in[1] = 36'o777777777777;
    wr_rq[0] = 1'b1; rq_cyc[0] = 1'b1;
    push(K_ACK, 0, d + 1, '0, '0);
    push(K_CWR, 0, d + 7, 36'o111777222666, 18'o123456);
    at_cyc(d + 1);
    wr_rs[0] = 1'b1;
    @(negedge clk);
    wr_rs[0] = 1'b0;
    at_cyc(d + 3);
    wr_rs[1] = 1'b1;
    @(negedge clk);
    wr_rs[1] = 1'b0;
    at_cyc(d + 6);
    wr_rs[0] = 1'b1;
    @(negedge clk);
    wr_rs[0] = 1'b0;
    rq_cyc[0] = 1'b0; wr_rq[0] = 1'b0;
    wait_idle("write_idle");

    // Deselected port is never granted.
    sel_en = 4'b1110;
    rq_cyc[0] = 1'b1; rd_rq[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("desel_busy", {63'd0, busy}, 64'd0);
    end
    rq_cyc[0] = 1'b0; rd_rq[0] = 1'b0;
    sel_en = 4'hF;

    // Read-write on port 3, abandoned in WWAIT: restore the read word.
    @(negedge clk);
    d = cyc;
    core_lat = 1;
    rd_word = 36'o4545;
    ma[3] = 18'o777001;
    rq_cyc[3] = 1'b1; rd_rq[3] = 1'b1; wr_rq[3] = 1'b1;
    push(K_ACK, 3, d + 1, '0, '0);
    push(K_CRD, 3, d + 2, '0, 18'o777001);
    push(K_RS,  3, d + 4, 36'o4545, '0);
    push(K_CWR, 3, d + 6, 36'o4545, 18'o777001);
    at_cyc(d + 5);
    rq_cyc[3] = 1'b0; rd_rq[3] = 1'b0; wr_rq[3] = 1'b0;
    wait_idle("abandon_idle");

    // Reset asserted while core_rd is high in RD: everything drops at once.
    @(negedge clk);
    d = cyc;
    core_lat = 5;
    rd_word = 36'o1234;
    ma[2] = 18'o55;
    rq_cyc[2] = 1'b1; rd_rq[2] = 1'b1;
    push(K_ACK, 2, d + 1, '0, '0);
    push(K_CRD, 2, d + 2, '0, 18'o55);
    at_cyc(d + 2);
    #2 reset = 1'b0;
    #1;
    chk("midrst_strobes", {60'd0, core_rd, core_wr, busy, 1'b0}, 64'd0);
    chk("midrst_acks", {56'd0, addr_ack, rd_rs}, 64'd0);
    chk("midrst_grant", {62'd0, grant}, 64'd0);
    chk("midrst_mb_out", {28'd0, mb_out}, 64'd0);
    chk("midrst_core_addr", {46'd0, core_addr}, 64'd0);
    chk("midrst_core_wdata", {28'd0, core_wdata}, 64'd0);
    rq_cyc[2] = 1'b0; rd_rq[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Normal grant after reset release.
    run_read(2, 18'o321, 36'o5670, 2);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Four-port arbiter and cycle sequencer for one core memory module. Shares the module's single core array between up to four memory-bus ports (processor, fast-memory side, I/O) gated by per-port select switches. Each granted port runs one complete bus cycle (read, write, or read-pause-write), and the core array performs it. The block sits between the memory-bus port wiring and the core storage array.

## Interface
- `NPORT`, 4: number of bus ports; fixed at 4.
- `ADDR_W`, 18: memory address width.
- `DATA_W`, 36: word width.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset (asserted at 0).
- `sel_en` in NPORT: per-port select switch; a port with bit 0 is never granted.
- `rq_cyc` in NPORT: port requests a cycle; held for the whole cycle.
- `rd_rq` in NPORT: cycle includes a read.
- `wr_rq` in NPORT: cycle includes a write.
- `ma` in NPORT×ADDR_W: per-port address.
- `wr_rs` in NPORT: write data valid on `mb_in`; one-cycle pulse.
- `mb_in` in NPORT×DATA_W: per-port write data.
- `addr_ack` out NPORT: address accepted; one-cycle pulse.
- `rd_rs` out NPORT: read data valid on `mb_out`; one-cycle pulse.
- `mb_out` out DATA_W: read data broadcast to all ports.
- `busy` out 1: a cycle is in progress.
- `grant` out 2: index of the current or last granted port.
- `core_rd` out 1: core read strobe; one-cycle pulse.
- `core_wr` out 1: core write strobe; one-cycle pulse.
- `core_addr` out ADDR_W: core address.
- `core_wdata` out DATA_W: core write data.
- `core_rdata` in DATA_W: core read data, valid with `core_done`.
- `core_done` in 1: core operation complete; one-cycle pulse.

## Operation
- States: IDLE, ACK, RD, RS, WWAIT, WR.
- **IDLE**
  - Eligible port: `rq_cyc & sel_en & (rd_rq | wr_rq)`.
  - On any eligible port: pick the winner, then latch `grant`, `ma`, `rd_rq`, and `wr_rq` into the cycle registers.
  - Next state is ACK; `busy` becomes 1.
- **ACK**
  - `addr_ack[grant]` = 1 for this one cycle.
  - Next state is RD if the latched read bit is set, otherwise WWAIT.
- **RD**
  - `core_rd` pulses in the first cycle of RD.
  - Hold in RD until `core_done`, then latch `core_rdata` into `mb_out` and into the write-back register; go to RS.
- **RS**
  - `rd_rs[grant]` = 1 for this one cycle.
  - Read-only cycle: go to WR with the write-back register, because core reads are destructive and the word must be restored.
  - Read-write cycle: go to WWAIT.
- **WWAIT**
  - On `wr_rs[grant]`: latch `mb_in[grant]` into `core_wdata`, go to WR.
  - On `rq_cyc[grant]` = 0 (port abandons the cycle): write the restore data instead, go to WR. For a write-only cycle the restore data is 0.
- **WR**
  - `core_wr` pulses in the first cycle of WR.
  - On `core_done`: go to IDLE, `busy` becomes 0.
- Inputs with no effect mid-cycle: `sel_en`, `ma`, `rd_rq`/`wr_rq`, and all non-granted ports. They are sampled only in IDLE.
- A `wr_rs` pulse outside WWAIT, or from a non-granted port, is ignored.
- Priority without the configuration macro: fixed, port 0 highest.

## Timing
- Reset values: every output 0, state IDLE. Asserting `reset` mid-cycle aborts the cycle immediately; the core strobes drop asynchronously.
- Cycle numbering: request sampled at edge 0; L = core latency in cycles from a strobe to `core_done`.
- Read-only cycle:
  - `addr_ack` at cycle 1, `core_rd` at cycle 2.
  - `rd_rs` at cycle 3+L, `core_wr` (restore) at cycle 4+L.
  - Back in IDLE after `core_done`; the next grant is possible on the edge after IDLE is re-entered.
- Write-only cycle: `addr_ack` at cycle 1; `core_wr` follows `wr_rs` by exactly 1 cycle.
- `core_done` arriving in the same cycle as the strobe (L=0) is legal and is handled.
- Simultaneous requests are resolved in a single IDLE cycle; there are no idle bubbles between back-to-back grants beyond the single IDLE cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`
  - Defined: rotating priority. Search starts at `last_grant+1` (mod 4); `last_grant` resets to 3, so port 0 wins first after reset.
  - Undefined: fixed priority, port 0 highest; the `last_grant` register is not built.

## Structure
- Package `mem_arb_pkg` holds:
  - `NPORT`, `ADDR_W`, `DATA_W`.
  - The state enum `arb_state_t` (IDLE, ACK, RD, RS, WWAIT, WR).
  - The cycle-type encoding.
- Sub-module `arb_prio_pick`: combinational NPORT-way picker. Inputs: eligible vector and start index. Outputs: valid flag and winner index. Fixed priority ties the start index to 0.

## Test plan
- Port 1 read-only, `ma`=0o10410, core returns 0o333 with L=3 → `addr_ack[1]` at cycle 1, `rd_rs[1]` at cycle 6 with `mb_out`=0o333, `core_wr` at cycle 7 with `core_wdata`=0o333.
- Port 0 write, `wr_rs[0]` 5 cycles after `addr_ack`, `mb_in`=0o111777222666 → `core_wr` exactly 1 cycle later with that data, `core_addr`=`ma[0]`.
- Ports 0 and 2 requesting continuously: fixed priority gives 0,0,0…; `MEM_ARB_ROUND_ROBIN_EN` gives 0,2,0,2.
- `sel_en`=0b1110 with only port 0 requesting → no `addr_ack`, `busy` stays 0.
- Read-write cycle, `rq_cyc` dropped in WWAIT → `core_wr` restores the read value, then IDLE.
- `reset`=0 during RD → all outputs 0 within the same cycle; after release a new request is granted normally.
